// File: rtl/sequence_player.sv
`default_nettype none
// sequence_player -- Simon playback: reads sequence_rom entries 0..level-1 and flashes each as a one-hot LED.
// Rev 1.0
module sequence_player #(
   parameter int DEPTH      = 16,
   parameter int ON_CYCLES  = 50000000,
   parameter int OFF_CYCLES = 12500000,
   parameter int CNT_W      = 26
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [3:0] level,
   output logic [3:0] rd_addr,
   input  logic [1:0] rd_data,
   output logic [3:0] led,
   output logic       busy,
   output logic       done
);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_SHOW  = 3'd3,
      S_GAP   = 3'd4,
      S_DONE  = 3'd5
   } state_t;

   // level is only 4 bits, so any DEPTH above 16 can never be the limiting term
   localparam logic [4:0]       DEPTH_CAP = (DEPTH > 16) ? 5'd16 : 5'(DEPTH);
   localparam logic [CNT_W-1:0] ON_LOAD   = CNT_W'(ON_CYCLES - 1);
   localparam logic [CNT_W-1:0] OFF_LOAD  = CNT_W'(OFF_CYCLES - 1);

   state_t           state, state_d;
   logic [3:0]       idx, idx_d;
   logic [4:0]       len, len_d;
   logic [CNT_W-1:0] timer, timer_d;
   logic [3:0]       led_d;
   logic [3:0]       addr_d;
   logic [4:0]       level_clamped;
   logic             last_step;

   assign level_clamped = ({1'b0, level} > DEPTH_CAP) ? DEPTH_CAP : {1'b0, level};
   assign last_step     = (({1'b0, idx} + 5'd1) == len);

   assign busy = (state == S_FETCH) || (state == S_WAIT) ||
                 (state == S_SHOW)  || (state == S_GAP);
   assign done = (state == S_DONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= S_IDLE;
         idx     <= '0;
         len     <= '0;
         timer   <= '0;
         led     <= '0;
         rd_addr <= '0;
      end else begin
         state   <= state_d;
         idx     <= idx_d;
         len     <= len_d;
         timer   <= timer_d;
         led     <= led_d;
         rd_addr <= addr_d;
      end
   end

   always_comb begin
      state_d = state;
      idx_d   = idx;
      len_d   = len;
      timer_d = timer;
      led_d   = led;
      addr_d  = rd_addr;
      case (state)
         S_IDLE: begin
            led_d = '0;
            if (start) begin
               idx_d = '0;
               len_d = level_clamped;
               if (level_clamped == 5'd0) begin
                  state_d = S_DONE;
               end else begin
                  addr_d  = '0;
                  state_d = S_FETCH;
               end
            end
         end
         S_FETCH: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // ROM output is valid only in this cycle; capture it straight into the LED drive
            led_d   = 4'b0001 << rd_data;
            timer_d = ON_LOAD;
            state_d = S_SHOW;
         end
         S_SHOW: begin
            if (timer == '0) begin
               led_d   = '0;
               timer_d = OFF_LOAD;
               state_d = S_GAP;
            end else begin
               timer_d = timer - CNT_W'(1);
            end
         end
         S_GAP: begin
            if (timer == '0) begin
               if (last_step) begin
                  state_d = S_DONE;
               end else begin
                  idx_d   = idx + 4'd1;
                  addr_d  = idx + 4'd1;
                  state_d = S_FETCH;
               end
            end else begin
               timer_d = timer - CNT_W'(1);
            end
         end
         S_DONE: begin
            led_d   = '0;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

endmodule
`default_nettype wire

// File: doc/sequence_player.md
Name: sequence_player

Overview:
Playback stage directly downstream of sequence_rom in the Simon game. On a start request it reads entries 0..level-1 from sequence_rom through the ROM's registered read port. It lights the matching colour LED for a fixed on-time, then holds all LEDs dark for a fixed gap, and pulses done after the last step. The game FSM uses done to hand control to player input.

Parameters:
DEPTH, 16, sequence_rom depth; maximum playable level
ON_CYCLES, 50000000, clock cycles each colour LED stays lit (>=1)
OFF_CYCLES, 12500000, clock cycles of dark gap after each colour (>=1)
CNT_W, 26, timer width; must hold max(ON_CYCLES, OFF_CYCLES)-1

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
start  input  1  single-cycle request to play the sequence; sampled only in IDLE
level  input  4  number of steps to play; sampled with start
rd_addr  output  4  read address to sequence_rom, registered
rd_data  input  2  colour from sequence_rom; valid the cycle after rd_addr is presented (1-cycle registered read)
led  output  4  one-hot colour drive, led = 4'b0001 << colour; 4'b0000 when dark
busy  output  1  high while playback is in progress
done  output  1  one-cycle pulse when playback completes

Behaviour:
- Reset (asynchronous assert, synchronous deassert seen at next edge): state=IDLE, rd_addr=0, led=0, busy=0, done=0, step index=0, timer=0.
- States: IDLE, FETCH, WAIT, SHOW, GAP, DONE.
- IDLE: led=0, busy=0. If start=1, latch len = min(level, DEPTH) and set idx=0.
  - len==0: go to DONE (no LED activity).
  - otherwise: go to FETCH with rd_addr=0.
- FETCH (1 cycle): rd_addr=idx is stable, so the ROM captures the address on the edge that ends FETCH. Next state is WAIT.
- WAIT (1 cycle): rd_data is valid. On the edge ending WAIT, register colour=rd_data and led=one-hot(colour). Load timer=ON_CYCLES-1. Next state is SHOW.
- SHOW: led held lit. Timer decrements each cycle. When timer==0, set led=0, load timer=OFF_CYCLES-1, and go to GAP.
- GAP: led=0. Timer decrements each cycle. When timer==0:
  - idx==len-1: go to DONE.
  - otherwise: idx+1, rd_addr=idx+1, go to FETCH.
- DONE (1 cycle): done=1, busy=0, led=0. Next state is IDLE.
- busy=1 in FETCH, WAIT, SHOW and GAP.
- Per-step cost is exactly ON_CYCLES+OFF_CYCLES+2 cycles. For len>0, busy is high for len*(ON_CYCLES+OFF_CYCLES+2) consecutive cycles, and done asserts in the cycle immediately after busy falls.
- start while busy or in DONE is ignored. level changes after the start sample have no effect.
- level>DEPTH is clamped to DEPTH, so rd_addr never exceeds DEPTH-1.
- led is always one-hot or zero, never multi-hot. Colour is taken only from the value registered in WAIT.
- Reset mid-playback: led=0 and busy=0 immediately (asynchronous). No done pulse is produced. The block returns to IDLE.
- Timer width is CNT_W. No arithmetic wraps: the timer is reloaded before reaching zero-minus-one.

Test Plan:
Setup for all scenarios: DEPTH=4, ON_CYCLES=4, OFF_CYCLES=2, sequence_rom instanced with 0:2'b01, 1:2'b11, 2:2'b00, 3:2'b10.
1. Reset then idle:
   - Stimulus: hold rst_n=0 for 3 cycles, release.
   - Required: led=0000, busy=0, done=0, rd_addr=0 throughout and for 5 idle cycles.
2. Full play:
   - Stimulus: start pulse with level=3.
   - Required: busy high for exactly 24 cycles; done high for exactly 1 cycle immediately after.
   - Required LED sequence: 0010 for 4 cycles, 0000 for 4 cycles (2 GAP + FETCH + WAIT), 1000 for 4 cycles, 0000 for 4 cycles, 0001 for 4 cycles, 0000 for 2 cycles.
   - Required: rd_addr steps 0, 1, 2.
3. Zero and clamp:
   - Stimulus: start with level=0.
   - Required: done pulses on the 2nd edge after start; led stays 0000; busy never rises.
   - Stimulus: start with level=9.
   - Required: exactly 4 colours play (0010, 1000, 0001, 0100); busy lasts 32 cycles; rd_addr never exceeds 3.
4. Start while busy:
   - Stimulus: a second start pulse with level=1, sent 10 cycles into a level=2 playback.
   - Required: ignored; busy lasts 16 cycles total; exactly one done pulse.
5. Reset mid-operation:
   - Stimulus: drive rst_n=0 during SHOW of step 1.
   - Required: led=0000 and busy=0 before the next clock edge; no done pulse.
   - Stimulus: after release, start with level=1.
   - Required: led=0010 for 4 cycles, then done.
